// File: rtl/ascii_time_parser_pkg.sv
// Shared constants and types for the ASCII "THH:MM:SS<CR>" time parser.
package ascii_time_parser_pkg;

  localparam logic [7:0] CHAR_T     = 8'h54;
  localparam logic [7:0] CHAR_COLON = 8'h3A;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_ZERO  = 8'h30;

  // Each state names the byte slot it is waiting for.
  typedef enum logic [3:0] {
    StIdle,
    StH1,
    StH0,
    StC1,
    StM1,
    StM0,
    StC2,
    StS1,
    StS0,
    StEol
  } state_e;

  typedef struct packed {
    logic [3:0] hour_t;
    logic [3:0] hour_u;
    logic [3:0] min_t;
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
  } bcd_time_t;

  // Digit slot check: must be an ASCII digit no larger than the field limit.
  function automatic logic digit_ok(input logic is_digit, input logic [3:0] bcd,
                                    input logic [3:0] max_val);
    return is_digit && (bcd <= max_val);
  endfunction

endpackage

// File: rtl/lcd_char_to_bcd.sv
// Combinational ASCII character to BCD digit decoder.
module lcd_char_to_bcd
  import ascii_time_parser_pkg::*;
(
  input  logic [7:0] ch,
  output logic [3:0] bcd,
  output logic       is_digit
);

  assign is_digit = (ch >= CHAR_ZERO) && (ch <= (CHAR_ZERO + 8'd9));
  // '0'..'9' are 0x30..0x39, so the low nibble is the BCD value.
  assign bcd      = ch[3:0];

endmodule

// File: rtl/ascii_time_parser.sv
// Parses "THH:MM:SS<CR>" byte streams into a BCD time, with range checks,
// frame restart on 'T', and an inter-byte idle timeout.
module ascii_time_parser
  import ascii_time_parser_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DIN,
  input  logic       DIN_VALID,
  output logic [3:0] HOUR_T,
  output logic [3:0] HOUR_U,
  output logic [3:0] MIN_T,
  output logic [3:0] MIN_U,
  output logic [3:0] SEC_T,
  output logic [3:0] SEC_U,
  output logic       SET,
  output logic       ERR,
  output logic       BUSY
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Abort happens on the idle cycle that would bring the count to TIMEOUT.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  bcd_time_t       shadow_q, shadow_d;
  bcd_time_t       time_q, time_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            set_q, set_d;
  logic            err_q, err_d;
  logic            busy_q;
  logic            abort;

  logic [3:0] bcd;
  logic       is_digit;

  lcd_char_to_bcd u_decode (
    .ch       (DIN),
    .bcd      (bcd),
    .is_digit (is_digit)
  );

  // Next-state, shadow capture, timeout counting and pulse generation.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    time_d   = time_q;
    cnt_d    = cnt_q;
    set_d    = 1'b0;
    err_d    = 1'b0;
    abort    = 1'b0;

    if (DIN_VALID) begin
      // A valid byte always clears the idle count, even on the timeout cycle.
      cnt_d = '0;
      unique case (state_q)
        StIdle: begin
          // Non-'T' bytes between frames are noise, not errors.
          if (DIN == CHAR_T) state_d = StH1;
        end
        StH1: begin
          if (digit_ok(is_digit, bcd, 4'd2)) begin
            shadow_d.hour_t = bcd;
            state_d         = StH0;
          end else abort = 1'b1;
        end
        StH0: begin
          if (digit_ok(is_digit, bcd, (shadow_q.hour_t == 4'd2) ? 4'd3 : 4'd9)) begin
            shadow_d.hour_u = bcd;
            state_d         = StC1;
          end else abort = 1'b1;
        end
        StC1: begin
          if (DIN == CHAR_COLON) state_d = StM1;
          else abort = 1'b1;
        end
        StM1: begin
          if (digit_ok(is_digit, bcd, 4'd5)) begin
            shadow_d.min_t = bcd;
            state_d        = StM0;
          end else abort = 1'b1;
        end
        StM0: begin
          if (digit_ok(is_digit, bcd, 4'd9)) begin
            shadow_d.min_u = bcd;
            state_d        = StC2;
          end else abort = 1'b1;
        end
        StC2: begin
          if (DIN == CHAR_COLON) state_d = StS1;
          else abort = 1'b1;
        end
        StS1: begin
          if (digit_ok(is_digit, bcd, 4'd5)) begin
            shadow_d.sec_t = bcd;
            state_d        = StS0;
          end else abort = 1'b1;
        end
        StS0: begin
          if (digit_ok(is_digit, bcd, 4'd9)) begin
            shadow_d.sec_u = bcd;
            state_d        = StEol;
          end else abort = 1'b1;
        end
        StEol: begin
          if (DIN == CHAR_CR) begin
            time_d   = shadow_q;
            shadow_d = '0;
            set_d    = 1'b1;
            state_d  = StIdle;
          end else abort = 1'b1;
        end
        default: state_d = StIdle;
      endcase

      if (abort) begin
        err_d    = 1'b1;
        shadow_d = '0;
        // A stray 'T' is treated as the start of a fresh frame.
        state_d  = (DIN == CHAR_T) ? StH1 : StIdle;
      end
    end else if (state_q != StIdle) begin
      if (cnt_q >= CntLast) begin
        err_d    = 1'b1;
        shadow_d = '0;
        cnt_d    = '0;
        state_d  = StIdle;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State, shadow, visible time and registered pulse/status outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      time_q   <= '0;
      cnt_q    <= '0;
      set_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      time_q   <= time_d;
      cnt_q    <= cnt_d;
      set_q    <= set_d;
      err_q    <= err_d;
      busy_q   <= (state_d != StIdle);
    end
  end

  assign HOUR_T = time_q.hour_t;
  assign HOUR_U = time_q.hour_u;
  assign MIN_T  = time_q.min_t;
  assign MIN_U  = time_q.min_u;
  assign SEC_T  = time_q.sec_t;
  assign SEC_U  = time_q.sec_u;
  assign SET    = set_q;
  assign ERR    = err_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_ascii_time_parser.sv
// Scoreboard bench for ascii_time_parser: expected SET/ERR events are queued
// when the triggering byte is driven and matched as the DUT pulses.
module tb_ascii_time_parser;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] DIN;
  logic       DIN_VALID;
  logic [3:0] HOUR_T, HOUR_U, MIN_T, MIN_U, SEC_T, SEC_U;
  logic       SET, ERR, BUSY;
  logic [23:0] cur_time;

  ascii_time_parser #(.TIMEOUT(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .DIN       (DIN),
    .DIN_VALID (DIN_VALID),
    .HOUR_T    (HOUR_T),
    .HOUR_U    (HOUR_U),
    .MIN_T     (MIN_T),
    .MIN_U     (MIN_U),
    .SEC_T     (SEC_T),
    .SEC_U     (SEC_U),
    .SET       (SET),
    .ERR       (ERR),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  assign cur_time = {HOUR_T, HOUR_U, MIN_T, MIN_U, SEC_T, SEC_U};

  typedef struct {
    bit          is_set;
    logic [23:0] t;
    int          cyc;
  } ev_t;

  ev_t         sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [23:0] model_time = '0;

  // Advance one clock, sample #1 later and retire any scoreboard event.
  task automatic step();
    ev_t e;
    @(posedge CLK);
    cyc++;
    #1;
    if (SET && ERR) begin
      checks++;
      errors++;
      $display("FAIL set_err_overlap cyc %0d: SET=%b ERR=%b, required not both", cyc, SET, ERR);
    end
    if (SET || ERR) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc %0d: SET=%b ERR=%b, required none", cyc, SET, ERR);
      end else begin
        e = sb.pop_front();
        if (e.is_set !== SET || e.cyc !== cyc || cur_time !== e.t) begin
          errors++;
          $display("FAIL event cyc %0d: SET=%b time=%h, required SET=%b time=%h at cyc %0d",
                   cyc, SET, cur_time, e.is_set, e.t, e.cyc);
        end
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      checks++;
      errors++;
      e = sb.pop_front();
      $display("FAIL missed_pulse cyc %0d: SET=0 ERR=0, required SET=%b time=%h",
               cyc, e.is_set, e.t);
    end
  endtask

  // ev: 0 none, 1 expect SET with time t, 2 expect ERR with time unchanged.
  task automatic send_byte(input logic [7:0] b, input int ev, input logic [23:0] t);
    if (ev == 1) begin
      sb.push_back('{1'b1, t, cyc + 1});
      model_time = t;
    end else if (ev == 2) begin
      sb.push_back('{1'b0, model_time, cyc + 1});
    end
    DIN       = b;
    DIN_VALID = 1'b1;
    step();
    DIN_VALID = 1'b0;
    DIN       = 8'h00;
  endtask

  task automatic send_str(input string s, input int err_at, input int set_at,
                          input logic [23:0] t);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], (i == set_at) ? 1 : ((i == err_at) ? 2 : 0), t);
  endtask

  task automatic test_reset();
    RST       = 1'b1;
    DIN       = 8'h00;
    DIN_VALID = 1'b0;
    repeat (3) step();
    checks++;
    if ({BUSY, SET, ERR} !== 3'b000 || cur_time !== 24'h0) begin
      errors++;
      $display("FAIL reset_state: busy/set/err=%b time=%h, required 000 000000",
               {BUSY, SET, ERR}, cur_time);
    end
    RST = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_valid_frame();
    send_str("T23:59:58\015", -1, 9, 24'h235958);
    repeat (3) step();
    checks++;
    if (cur_time !== 24'h235958 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL valid_frame: time=%h busy=%b, required 235958 0", cur_time, BUSY);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL valid_frame_pending: %0d events, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_hour_range();
    send_str("T24:00:00\015", 2, -1, 24'h0);
    repeat (3) step();
    checks++;
    if (cur_time !== 24'h235958 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL hour_range: time=%h busy=%b, required 235958 0", cur_time, BUSY);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL hour_range_pending: %0d events, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_field_errors();
    send_str("T12:60", 4, -1, 24'h0);
    send_str("T12:00:6", 7, -1, 24'h0);
    send_str("T12-", 3, -1, 24'h0);
    send_str("T12:00:00X", 9, -1, 24'h0);
    send_str("T3", 1, -1, 24'h0);
    repeat (3) step();
    checks++;
    if (cur_time !== 24'h235958 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL field_errors: time=%h busy=%b, required 235958 0", cur_time, BUSY);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL field_errors_pending: %0d events, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_restart();
    send_str("T12:3T08:15:00\015", 5, 14, 24'h081500);
    repeat (3) step();
    checks++;
    if (cur_time !== 24'h081500) begin
      errors++;
      $display("FAIL restart: time=%h, required 081500", cur_time);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL restart_pending: %0d events, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_timeout();
    send_str("T12", -1, -1, 24'h0);
    sb.push_back('{1'b0, model_time, cyc + 16});
    repeat (16) step();
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL timeout_busy: busy=%b, required 0", BUSY);
    end
    // Fifteen idle cycles then the next byte lands on the would-be timeout edge.
    send_str("T12", -1, -1, 24'h0);
    repeat (15) step();
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL timeout_hold_busy: busy=%b, required 1", BUSY);
    end
    send_str(":34:56\015", -1, 6, 24'h123456);
    repeat (3) step();
    checks++;
    if (cur_time !== 24'h123456) begin
      errors++;
      $display("FAIL timeout_resume: time=%h, required 123456", cur_time);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL timeout_pending: %0d events, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_mid_frame();
    send_str("T12:3", -1, -1, 24'h0);
    RST = 1'b1;
    #1;
    checks++;
    if (BUSY !== 1'b0 || ERR !== 1'b0 || cur_time !== 24'h0) begin
      errors++;
      $display("FAIL reset_mid_frame: busy=%b err=%b time=%h, required 0 0 000000",
               BUSY, ERR, cur_time);
    end
    model_time = 24'h0;
    repeat (2) step();
    RST = 1'b0;
    step();
    send_str("T01:02:03\015", -1, 9, 24'h010203);
    repeat (3) step();
    checks++;
    if (cur_time !== 24'h010203) begin
      errors++;
      $display("FAIL reset_reparse: time=%h, required 010203", cur_time);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL reset_pending: %0d events, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_garbage();
    logic [7:0] junk [3];
    junk = '{8'h41, 8'h0D, 8'h39};
    for (int i = 0; i < 3; i++) begin
      send_byte(junk[i], 0, 24'h0);
      checks++;
      if (BUSY !== 1'b0) begin
        errors++;
        $display("FAIL garbage_busy byte %h: busy=%b, required 0", junk[i], BUSY);
      end
    end
    repeat (3) step();
    checks++;
    if (cur_time !== 24'h010203 || sb.size() != 0) begin
      errors++;
      $display("FAIL garbage: time=%h pending=%0d, required 010203 0", cur_time, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_back_to_back();
    send_str("T00:00:00\015", -1, 9, 24'h000000);
    send_str("T19:59:59\015", -1, 9, 24'h195959);
    repeat (3) step();
    checks++;
    if (cur_time !== 24'h195959 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back: time=%h busy=%b, required 195959 0", cur_time, BUSY);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_pending: %0d events, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_hour_range();
    test_field_errors();
    test_restart();
    test_timeout();
    test_reset_mid_frame();
    test_garbage();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
